// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter
// Shares one account balance between NUM_REQ ATM terminals. Terminals are
// served one at a time in round-robin order. Each operation runs atomically
// against the shared balance, and the served terminal gets a one-cycle done
// pulse that carries a status code and the resulting balance.
//
// Ports:
//   clk, rst     clock (rising edge), synchronous active-high reset
//   req          per-terminal request, held until the matching done
//   op_flat      per-terminal op, 2 bits each (00 wd, 01 dep, 10 inq, 11 rsvd)
//   amt_flat     per-terminal amount, AMT_W bits each
//   gnt          one-hot, terminal being served
//   done         one-hot, one-cycle completion pulse
//   status       result code, valid while done != 0
//   balance_out  balance after the operation, valid while done != 0
//   busy         FSM not idle
//   txn_count    count of OK transactions, wraps at 16 bits
module atm_account_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BAL_W        = 8,
  parameter int unsigned AMT_W        = 6,
  parameter int unsigned INIT_BALANCE = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [2*NUM_REQ-1:0]     op_flat,
  input  logic [AMT_W*NUM_REQ-1:0] amt_flat,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [1:0]               status,
  output logic [BAL_W-1:0]         balance_out,
  output logic                     busy,
  output logic [15:0]              txn_count
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          NumReqI = int'(NUM_REQ);

  localparam logic [1:0] OpWithdraw = 2'b00;
  localparam logic [1:0] OpDeposit  = 2'b01;
  localparam logic [1:0] OpInquiry  = 2'b10;

  localparam logic [1:0] StsOk       = 2'b00;
  localparam logic [1:0] StsInsuff   = 2'b01;
  localparam logic [1:0] StsOverflow = 2'b10;
  localparam logic [1:0] StsBadReq   = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      winner_q, winner_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]           op_q, op_d;
  logic [AMT_W-1:0]     amt_q, amt_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [1:0]           status_q, status_d;
  logic [BAL_W-1:0]     bal_out_q, bal_out_d;
  logic [15:0]          txn_q, txn_d;

  // Unpacked views of the flattened per-terminal inputs.
  logic [1:0]       op_arr  [NUM_REQ];
  logic [AMT_W-1:0] amt_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NumReqI; i++) begin
      op_arr[i]  = op_flat[2*i +: 2];
      amt_arr[i] = amt_flat[AMT_W*i +: AMT_W];
    end
  end

  // Round-robin pick: scan downward so the candidate closest to rr_ptr wins.
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NumReqI - 1; k >= 0; k--) begin
      cand = IdxW'((int'(rr_ptr_q) + k) % NumReqI);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Operation evaluation against the current balance.
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   sum;
  logic [BAL_W-1:0] exec_bal;
  logic [1:0]       exec_status;

  always_comb begin
    amt_ext     = BAL_W'(amt_q);
    sum         = {1'b0, balance_q} + {1'b0, amt_ext};
    exec_bal    = balance_q;
    exec_status = StsOk;
    case (op_q)
      OpWithdraw: begin
        if (amt_q == '0) begin
          exec_status = StsBadReq;
        end else if (amt_ext > balance_q) begin
          exec_status = StsInsuff;
        end else begin
          exec_bal = balance_q - amt_ext;
        end
      end
      OpDeposit: begin
        if (amt_q == '0) begin
          exec_status = StsBadReq;
        end else if (sum[BAL_W]) begin
          exec_status = StsOverflow;
        end else begin
          exec_bal = sum[BAL_W-1:0];
        end
      end
      OpInquiry: exec_status = StsOk;
      default:   exec_status = StsBadReq;
    endcase
  end

  logic [IdxW-1:0] rr_next;
  assign rr_next = (int'(winner_q) == NumReqI - 1) ? '0 : winner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    rr_ptr_d  = rr_ptr_q;
    op_d      = op_q;
    amt_d     = amt_q;
    balance_d = balance_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    status_d  = status_q;
    bal_out_d = bal_out_q;
    txn_d     = txn_q;
    unique case (state_q)
      StIdle: begin
        // gnt lingers through the done cycle so done always has its gnt bit.
        gnt_d = '0;
        if (pick_valid) begin
          winner_d = pick_idx;
          op_d     = op_arr[pick_idx];
          amt_d    = amt_arr[pick_idx];
          gnt_d    = NUM_REQ'(1) << pick_idx;
          state_d  = StExec;
        end
      end
      StExec: begin
        status_d  = exec_status;
        bal_out_d = exec_bal;
        if (exec_status == StsOk) begin
          balance_d = exec_bal;
        end
        state_d = StResp;
      end
      StResp: begin
        done_d   = gnt_q;
        rr_ptr_d = rr_next;
        if (status_q == StsOk) begin
          txn_d = txn_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      winner_q  <= '0;
      rr_ptr_q  <= '0;
      op_q      <= '0;
      amt_q     <= '0;
      balance_q <= BAL_W'(INIT_BALANCE);
      gnt_q     <= '0;
      done_q    <= '0;
      status_q  <= '0;
      bal_out_q <= '0;
      txn_q     <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      rr_ptr_q  <= rr_ptr_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
      balance_q <= balance_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      status_q  <= status_d;
      bal_out_q <= bal_out_d;
      txn_q     <= txn_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign status      = status_q;
  assign balance_out = bal_out_q;
  assign busy        = (state_q != StIdle);
  assign txn_count   = txn_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Scoreboard bench for atm_account_arbiter: stimulus pushes the expected done
// response, a monitor pops and compares each time done pulses.
module tb_atm_account_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [7:0]  op_flat = '0;
  logic [23:0] amt_flat = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [1:0]  status;
  logic [7:0]  balance_out;
  logic        busy;
  logic [15:0] txn_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  done;
    logic [1:0]  status;
    logic [7:0]  bal;
    logic [15:0] txn;
  } exp_t;

  exp_t exp_q[$];

  atm_account_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .op_flat     (op_flat),
    .amt_flat    (amt_flat),
    .gnt         (gnt),
    .done        (done),
    .status      (status),
    .balance_out (balance_out),
    .busy        (busy),
    .txn_count   (txn_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endfunction

  // Monitor: scoreboard pop on every done pulse, plus per-cycle invariants.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (done != '0) begin
          chk("done_has_gnt", 32'(done & ~gnt), 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_vec", 32'(done), 32'(e.done));
            chk("status", 32'(status), 32'(e.status));
            chk("balance_out", 32'(balance_out), 32'(e.bal));
            chk("txn_count", 32'(txn_count), 32'(e.txn));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    op_flat = '0;
    amt_flat = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int idx, input logic [1:0] st, input logic [7:0] bal,
                      input logic [15:0] t);
    exp_t e;
    e.done = 4'b0001 << idx;
    e.status = st;
    e.bal = bal;
    e.txn = t;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [1:0] op, input logic [5:0] amt);
    req[idx] = 1'b1;
    op_flat[2*idx +: 2] = op;
    amt_flat[6*idx +: 6] = amt;
  endtask

  // Waits (bounded) past at least one edge for done[idx], then drops req[idx].
  task automatic wait_done(input int idx);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done[idx] !== 1'b1 && n < 20);
    if (done[idx] !== 1'b1) chk("done_timeout", 32'd0, 32'd1);
    req[idx] = 1'b0;
  endtask

  task automatic wait_any(output int c);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done == '0 && n < 20);
    if (done == '0) chk("any_done_timeout", 32'd0, 32'd1);
    c = cyc;
  endtask

  task automatic txn(input int idx, input logic [1:0] op, input logic [5:0] amt,
                     input logic [1:0] st, input logic [7:0] bal, input logic [15:0] t);
    push(idx, st, bal, t);
    @(negedge clk);
    set_req(idx, op, amt);
    wait_done(idx);
  endtask

  initial begin
    int c_prev;
    int c_now;

    // Reset values and first-transaction latency.
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_balance_out", 32'(balance_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    push(0, 2'b00, 8'd20, 16'd1);
    @(negedge clk);
    set_req(0, 2'b00, 6'd10);
    @(posedge clk);
    #1;
    chk("lat_gnt", 32'(gnt), 32'h1);
    chk("lat_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_no_done_yet", 32'(done), 32'd0);
    wait_done(0);

    // Insufficient funds, then withdraw exactly the balance.
    do_reset();
    txn(1, 2'b00, 6'd40, 2'b01, 8'd30, 16'd0);
    txn(1, 2'b00, 6'd30, 2'b00, 8'd0, 16'd1);

    // Deposit overflow.
    do_reset();
    txn(2, 2'b01, 6'd63, 2'b00, 8'd93, 16'd1);
    txn(2, 2'b01, 6'd63, 2'b00, 8'd156, 16'd2);
    txn(2, 2'b01, 6'd63, 2'b00, 8'd219, 16'd3);
    txn(2, 2'b01, 6'd63, 2'b10, 8'd219, 16'd3);

    // All four terminals held: round-robin order 0,1,2,3,0 at 3-cycle spacing.
    do_reset();
    push(0, 2'b00, 8'd29, 16'd1);
    push(1, 2'b00, 8'd28, 16'd2);
    push(2, 2'b00, 8'd27, 16'd3);
    push(3, 2'b00, 8'd26, 16'd4);
    push(0, 2'b00, 8'd25, 16'd5);
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, 2'b00, 6'd1);
    c_prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_any(c_now);
      if (k > 0) chk("rr_spacing", 32'(c_now - c_prev), 32'd3);
      c_prev = c_now;
    end
    req = '0;

    // Bad requests leave balance and count untouched.
    do_reset();
    txn(0, 2'b11, 6'd5, 2'b11, 8'd30, 16'd0);
    txn(1, 2'b01, 6'd0, 2'b11, 8'd30, 16'd0);

    // Reset during EXEC discards the transaction.
    do_reset();
    @(negedge clk);
    set_req(0, 2'b01, 6'd20);
    @(posedge clk);
    #1;
    chk("mid_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_gnt_clr", 32'(gnt), 32'd0);
    chk("mid_txn", 32'(txn_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    repeat (4) @(negedge clk);
    txn(3, 2'b10, 6'd0, 2'b00, 8'd30, 16'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
